// File: rtl/sw_cond_pkg.sv
// Shared types and defaults for the switch conditioner.
package sw_cond_pkg;

    localparam int DEFAULT_DEBOUNCE = 16;

    typedef enum logic [1:0] {
        LOW       = 2'd0,
        PEND_HIGH = 2'd1,
        HIGH      = 2'd2,
        PEND_LOW  = 2'd3
    } hs_state_t;

endpackage

// File: rtl/sw_cond_if.sv
// Raw switch inputs towards the conditioner and conditioned outputs towards the core.
interface sw_cond_if #(parameter int N = 8);

    logic [N-1:0] sw_data_raw;
    logic         sw_hs_raw;
    logic [N-1:0] sw_data;
    logic         sw_hs;
    logic         hs_rise;
    logic         hs_fall;

    modport master (
        output sw_data_raw, sw_hs_raw,
        input  sw_data, sw_hs, hs_rise, hs_fall
    );

    modport slave (
        input  sw_data_raw, sw_hs_raw,
        output sw_data, sw_hs, hs_rise, hs_fall
    );

endinterface

// File: rtl/sync2.sv
// Two-flop synchroniser for asynchronous level inputs.
// Latency: 2 cycles.
// Backpressure: none, free-running.
module sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] r1;
    logic [W-1:0] r2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r1 <= '0;
            r2 <= '0;
        end else begin
            r1 <= d;
            r2 <= r1;
        end
    end

    assign q = r2;

endmodule

// File: rtl/sw_conditioner.sv
// Synchronises switches, debounces the handshake and freezes data at each accepted edge.
// Latency: DEBOUNCE_CYCLES+2 edges from raw handshake change to sw_hs/pulse (data settled).
// Backpressure: none; acceptance waits for the data bus to be stable DEBOUNCE_CYCLES cycles.
module sw_conditioner
    import sw_cond_pkg::*;
#(
    parameter int N               = 8,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE
) (
    input  logic       clk,
    input  logic       reset,
    sw_cond_if.slave   bus
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [N:0]    sync_q;
    logic [N-1:0]  s_data;
    logic          s_hs;
    logic [N-1:0]  s_data_q;
    logic [CW-1:0] dcnt;
    logic          settled;

    hs_state_t     state;
    logic [CW-1:0] hcnt;
    logic          hs_q;
    logic [N-1:0]  data_q;
    logic          rise_q;
    logic          fall_q;

    sync2 #(.W(N + 1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     ({bus.sw_hs_raw, bus.sw_data_raw}),
        .q     (sync_q)
    );

    assign s_data  = sync_q[N-1:0];
    assign s_hs    = sync_q[N];
    assign settled = (dcnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            s_data_q <= '0;
            dcnt     <= '0;
        end else begin
            s_data_q <= s_data;
            if (s_data != s_data_q)
                dcnt <= '0;
            else if (dcnt != CNT_MAX)
                dcnt <= dcnt + CW'(1);
        end
    end

    // A pending edge saturates at CNT_LAST and waits there until the data bus has settled.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= LOW;
            hcnt   <= '0;
            hs_q   <= 1'b0;
            data_q <= '0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            case (state)
                LOW: begin
                    if (s_hs) begin
                        state <= PEND_HIGH;
                        hcnt  <= CW'(1);
                    end
                end
                PEND_HIGH: begin
                    if (!s_hs) begin
                        state <= LOW;
                        hcnt  <= '0;
                    end else if (hcnt < CNT_LAST) begin
                        hcnt <= hcnt + CW'(1);
                    end else if (settled) begin
                        state  <= HIGH;
                        hcnt   <= '0;
                        hs_q   <= 1'b1;
                        data_q <= s_data;
                        rise_q <= 1'b1;
                    end
                end
                HIGH: begin
                    if (!s_hs) begin
                        state <= PEND_LOW;
                        hcnt  <= CW'(1);
                    end
                end
                PEND_LOW: begin
                    if (s_hs) begin
                        state <= HIGH;
                        hcnt  <= '0;
                    end else if (hcnt < CNT_LAST) begin
                        hcnt <= hcnt + CW'(1);
                    end else if (settled) begin
                        state  <= LOW;
                        hcnt   <= '0;
                        hs_q   <= 1'b0;
                        data_q <= s_data;
                        fall_q <= 1'b1;
                    end
                end
                default: begin
                    state <= LOW;
                    hcnt  <= '0;
                end
            endcase
        end
    end

    assign bus.sw_data = data_q;
    assign bus.sw_hs   = hs_q;
    assign bus.hs_rise = rise_q;
    assign bus.hs_fall = fall_q;

endmodule

// File: tb/tb_sw_conditioner.sv
// Directed stimulus with a pulse scoreboard for sw_conditioner at DEBOUNCE_CYCLES=4.
module tb_sw_conditioner;
    import sw_cond_pkg::*;

    typedef struct {
        bit         rise;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic rst_q = 1'b1;
    int   cyc   = 0;
    int   checks = 0;
    int   errors = 0;

    logic       exp_lvl = 1'b0;
    logic [7:0] exp_dat = 8'h00;
    exp_t       q[$];

    always #5 clk = ~clk;

    sw_cond_if #(.N(8)) bus ();

    sw_conditioner #(.N(8), .DEBOUNCE_CYCLES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= reset;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // off = edges from now (just after edge cyc) to the committing edge
    task automatic expect_edge(input bit rise, input logic [7:0] d, input int off);
        exp_t e;
        e.rise = rise;
        e.data = d;
        e.cyc  = cyc + off;
        q.push_back(e);
    endtask

    // Monitor: pops one expectation per pulse and tracks the expected held level/data.
    always @(negedge clk) begin
        if (cyc > 0) begin
            if (rst_q === 1'b1) begin
                exp_lvl = 1'b0;
                exp_dat = 8'h00;
                chk("no pulse in reset", {30'd0, bus.hs_rise, bus.hs_fall}, 32'd0);
            end else if (bus.hs_rise || bus.hs_fall) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious pulse actual rise=%0b fall=%0b required none (cycle %0d)",
                             bus.hs_rise, bus.hs_fall, cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("pulse rise", {31'd0, bus.hs_rise}, {31'd0, e.rise});
                    chk("pulse fall", {31'd0, bus.hs_fall}, {31'd0, !e.rise});
                    chk("pulse cycle", cyc, e.cyc);
                    chk("captured data", {24'd0, bus.sw_data}, {24'd0, e.data});
                    exp_lvl = e.rise;
                    exp_dat = e.data;
                end
            end
            chk("sw_hs level", {31'd0, bus.sw_hs}, {31'd0, exp_lvl});
            chk("sw_data hold", {24'd0, bus.sw_data}, {24'd0, exp_dat});
        end
    end

    initial begin
        bus.sw_data_raw = 8'h5A;
        bus.sw_hs_raw   = 1'b0;
        reset           = 1'b1;
        step(3);
        chk("reset state", 32'(dut.state), 32'(LOW));
        chk("reset hcnt", 32'(dut.hcnt), 32'd0);
        chk("reset dcnt", 32'(dut.dcnt), 32'd0);
        chk("reset sync r1", {23'd0, dut.u_sync.r1}, 32'd0);
        chk("reset sync r2", {23'd0, dut.u_sync.r2}, 32'd0);
        chk("reset outputs", {22'd0, bus.sw_data, bus.sw_hs, bus.hs_rise, bus.hs_fall}, 32'd0);

        reset = 1'b0;
        step(12);
        chk("data ignored without edge", {24'd0, bus.sw_data}, 32'd0);

        // Rise with settled data 25: commit 6 edges after the drive point
        bus.sw_data_raw = 8'd25;
        step(8);
        bus.sw_hs_raw = 1'b1;
        expect_edge(1'b1, 8'h19, 6);
        step(10);
        chk("rise drained", q.size(), 32'd0);

        bus.sw_hs_raw = 1'b0;
        expect_edge(1'b0, 8'h19, 6);
        step(10);

        // Two-cycle bounce must be rejected
        bus.sw_hs_raw = 1'b1;
        step(2);
        bus.sw_hs_raw = 1'b0;
        step(12);
        chk("bounce sw_hs", {31'd0, bus.sw_hs}, 32'd0);
        chk("bounce state", 32'(dut.state), 32'(LOW));

        // Data changes one cycle after the fall: commit waits for settle (drive+9)
        bus.sw_data_raw = 8'd78;
        step(8);
        bus.sw_hs_raw = 1'b1;
        expect_edge(1'b1, 8'h4E, 6);
        step(10);
        bus.sw_hs_raw = 1'b0;
        expect_edge(1'b0, 8'hBF, 9);
        step(1);
        bus.sw_data_raw = 8'hBF;
        step(14);
        chk("late fall drained", q.size(), 32'd0);

        // Full handshake x1=-32, y1=6
        bus.sw_data_raw = 8'hE0;
        step(8);
        bus.sw_hs_raw = 1'b1;
        expect_edge(1'b1, 8'hE0, 6);
        step(10);
        bus.sw_data_raw = 8'h06;
        step(8);
        bus.sw_hs_raw = 1'b0;
        expect_edge(1'b0, 8'h06, 6);
        step(10);

        // Reset while pending with hcnt=2, then re-accept after release
        bus.sw_data_raw = 8'h00;
        step(8);
        bus.sw_hs_raw = 1'b1;
        step(4);
        chk("pending state", 32'(dut.state), 32'(PEND_HIGH));
        chk("pending hcnt", 32'(dut.hcnt), 32'd2);
        reset = 1'b1;
        step(1);
        chk("mid reset state", 32'(dut.state), 32'(LOW));
        chk("mid reset hcnt", 32'(dut.hcnt), 32'd0);
        chk("mid reset outputs", {22'd0, bus.sw_data, bus.sw_hs, bus.hs_rise, bus.hs_fall}, 32'd0);
        reset = 1'b0;
        expect_edge(1'b1, 8'h00, 6);
        step(12);

        for (int i = 0; i < 50 && q.size() != 0; i++) step(1);
        chk("scoreboard drained", q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
